// File: rtl/gate_test_sequencer.sv
// Drives the four 2-input vectors to two gate implementations, compares their outputs and reports the result.
// Optional macro GATE_SEQ_TRUTH_CAPTURE_EN builds the per-vector truth-table capture register.
module gate_test_sequencer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       a_in,
    input  logic       b_in,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic [2:0] mismatch_cnt,
    output logic       pass,
    output logic [3:0] truth
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned VEC_W = 2;
    localparam int unsigned MIS_W = 3;
    localparam int unsigned TT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [VEC_W-1:0]   vec, vec_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [MIS_W-1:0]   mis_n;
    logic               pass_n;
    logic               active_n;
`ifdef GATE_SEQ_TRUTH_CAPTURE_EN
    logic [TT_W-1:0]    truth_n;
`endif

    // Next-state and next-value logic; outputs are registered from these values so they line up with the state.
    always_comb begin
        state_n = state;
        vec_n   = vec;
        cnt_n   = cnt;
        mis_n   = mismatch_cnt;
        pass_n  = pass;
`ifdef GATE_SEQ_TRUTH_CAPTURE_EN
        truth_n = truth;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = DRIVE;
                    vec_n   = '0;
                    cnt_n   = CNT_W'(SETTLE);
                    mis_n   = '0;
`ifdef GATE_SEQ_TRUTH_CAPTURE_EN
                    truth_n = '0;
`endif
                end
            end
            DRIVE: begin
                if (cnt <= CNT_W'(1)) begin
                    state_n = SAMPLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (a_in != b_in) begin
                    mis_n = mismatch_cnt + MIS_W'(1);
                end
`ifdef GATE_SEQ_TRUTH_CAPTURE_EN
                truth_n[vec] = a_in;
`endif
                if (vec == VEC_W'(3)) begin
                    state_n = DONE;
                    // pass must include the increment from this final sample
                    pass_n  = (mis_n == '0);
                end else begin
                    state_n = DRIVE;
                    vec_n   = vec + VEC_W'(1);
                    cnt_n   = CNT_W'(SETTLE);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign active_n = (state_n == DRIVE) || (state_n == SAMPLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            vec          <= '0;
            cnt          <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
            x            <= 1'b0;
            y            <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            vec          <= vec_n;
            cnt          <= cnt_n;
            mismatch_cnt <= mis_n;
            pass         <= pass_n;
            x            <= active_n & vec_n[1];
            y            <= active_n & vec_n[0];
            busy         <= active_n;
            done         <= (state_n == DONE);
        end
    end

`ifdef GATE_SEQ_TRUTH_CAPTURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            truth <= '0;
        end else begin
            truth <= truth_n;
        end
    end
`else
    assign truth = TT_W'(0);
`endif

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Scoreboard bench for gate_test_sequencer: SETTLE=1 instance for runs/reset, SETTLE=3 instance for held-start timing.
module tb_gate_test_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start1, a1, b1, x1, y1, busy1, done1, pass1;
    logic [2:0] mis1;
    logic [3:0] truth1;
    logic       start3, a3, b3, x3, y3, busy3, done3, pass3;
    logic [2:0] mis3;
    logic [3:0] truth3;

    int a_mode = 0;
    int b_mode = 0;

    function automatic logic gate_f(input int mode, input logic gx, input logic gy);
        case (mode)
            0:       return ~(gx ^ gy);
            1:       return gx ^ gy;
            default: return 1'b0;
        endcase
    endfunction

    assign a1 = gate_f(a_mode, x1, y1);
    assign b1 = gate_f(b_mode, x1, y1);
    assign a3 = ~(x3 ^ y3);
    assign b3 = ~(x3 ^ y3);

    gate_test_sequencer #(.SETTLE(1)) u_dut (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1),
        .x(x1), .y(y1), .busy(busy1), .done(done1),
        .mismatch_cnt(mis1), .pass(pass1), .truth(truth1)
    );

    gate_test_sequencer #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .a_in(a3), .b_in(b3),
        .x(x3), .y(y3), .busy(busy3), .done(done3),
        .mismatch_cnt(mis3), .pass(pass3), .truth(truth3)
    );

    typedef struct {
        int mis;
        int pass;
        int truth;
        int start_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Pop one expectation per done pulse of the SETTLE=1 instance.
    always @(negedge clk) begin
        if (!rst && done1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("mismatch_cnt", 32'(mis1), 32'(mon_e.mis));
                check("pass", 32'(pass1), 32'(mon_e.pass));
                check("truth", 32'(truth1), 32'(mon_e.truth));
                check("done_latency", 32'(cyc - mon_e.start_cyc), 32'd9);
                check("xy_zero_in_done", 32'({x1, y1}), 32'd0);
            end
        end
    end

    function automatic exp_t model(input int am, input int bm);
        exp_t e;
        logic [3:0] tt;
        logic av, bv;
        e.mis = 0;
        tt    = 4'b0000;
        for (int v = 0; v < 4; v++) begin
            av = gate_f(am, v[1], v[0]);
            bv = gate_f(bm, v[1], v[0]);
            if (av != bv) e.mis++;
            tt[v] = av;
        end
        e.pass = (e.mis == 0) ? 1 : 0;
`ifdef GATE_SEQ_TRUTH_CAPTURE_EN
        e.truth = int'(tt);
`else
        e.truth = 0;
`endif
        e.start_cyc = 0;
        return e;
    endfunction

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic run1(input int am, input int bm);
        exp_t e;
        a_mode = am;
        b_mode = bm;
        e = model(am, bm);
        @(negedge clk);
        start1 = 1'b1;
        e.start_cyc = cyc;
        sb.push_back(e);
        last_exp = e;
        @(negedge clk);
        start1 = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        check("hold_mismatch_cnt", 32'(mis1), 32'(last_exp.mis));
        check("hold_pass", 32'(pass1), 32'(last_exp.pass));
        check("hold_truth", 32'(truth1), 32'(last_exp.truth));
        check("idle_busy", 32'(busy1), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"}, 32'(x1), 32'd0);
        check({tag, "_y"}, 32'(y1), 32'd0);
        check({tag, "_busy"}, 32'(busy1), 32'd0);
        check({tag, "_done"}, 32'(done1), 32'd0);
        check({tag, "_mis"}, 32'(mis1), 32'd0);
        check({tag, "_pass"}, 32'(pass1), 32'd0);
        check({tag, "_truth"}, 32'(truth1), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int found;
        int n_done, first_done, second_done;
        logic busy18, busy19;

        rst    = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("reset3_busy", 32'(busy3), 32'd0);
        check("reset3_done", 32'(done3), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run1(0, 0);   // XNOR vs XNOR
        run1(0, 1);   // XNOR vs XOR
        run1(2, 0);   // stuck-0 vs XNOR
        run1(0, 2);   // XNOR vs stuck-0
        run1(1, 1);   // XOR vs XOR

        // Abort a run in DRIVE with vec=2.
        a_mode = 0;
        b_mode = 0;
        @(negedge clk);
        start1 = 1'b1;
        sb.push_back(model(0, 0));
        @(negedge clk);
        start1 = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (busy1 && x1 && !y1) found = 1;
            else @(negedge clk);
        end
        check("reach_vec2", 32'(found), 32'd1);
        #1 rst = 1'b1;
        sb.delete();
        #1 check_all_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_all_zero("post_abort_idle");
        run1(0, 0);

        // SETTLE=3 instance: start held for 20 cycles.
        @(negedge clk);
        start3      = 1'b1;
        n_done      = 0;
        first_done  = 0;
        second_done = 0;
        busy18      = 1'b0;
        busy19      = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (done3) begin
                n_done++;
                if (n_done == 1) first_done = i;
                else if (n_done == 2) second_done = i;
            end
            if (i == 18) busy18 = busy3;
            if (i == 19) busy19 = busy3;
            if (i == 20) start3 = 1'b0;
        end
        check("s3_done_count", 32'(n_done), 32'd2);
        check("s3_first_done", 32'(first_done), 32'd17);
        check("s3_second_done", 32'(second_done), 32'd35);
        check("s3_idle_gap_busy", 32'(busy18), 32'd0);
        check("s3_restart_busy", 32'(busy19), 32'd1);
        check("s3_mismatch_cnt", 32'(mis3), 32'd0);
        check("s3_pass", 32'(pass3), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
